uart_rx_oversample: RTL and testbench

//  UART receiver and sink of the 16x oversampling tick from the baud generator.

---
 rtl/uart_rx_oversample.sv | 149 ++++++++++++++
 tb/tb_uart_rx_oversample.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversample.sv
// rtl/uart_rx_oversample.sv - 8N1 UART receiver clocked by a 16x oversampling baud tick
// Synchronises rx, samples mid-bit, flags framing errors and waits out a break.
module uart_rx_oversample #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 baud_tick,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [TW-1:0] TICK_ONE  = TW'(1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] BIT_ONE   = BW'(1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } state_t;

   state_t               state;
   state_t               state_nx;
   logic [TW-1:0]        tick_cnt;
   logic [TW-1:0]        tick_cnt_nx;
   logic [BW-1:0]        bit_cnt;
   logic [BW-1:0]        bit_cnt_nx;
   logic [DATA_BITS-1:0] shreg;
   logic [DATA_BITS-1:0] shreg_nx;
   logic                 rx_meta;
   logic                 rx_s;
   logic                 valid_nx;
   logic                 err_nx;

   // Both stages reset high so a reset never fabricates a start edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         tick_cnt  <= '0;
         bit_cnt   <= '0;
         shreg     <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_nx;
         tick_cnt  <= tick_cnt_nx;
         bit_cnt   <= bit_cnt_nx;
         shreg     <= shreg_nx;
         rx_valid  <= valid_nx;
         frame_err <= err_nx;
         if (valid_nx) begin
            rx_data <= shreg;
         end
      end
   end

   // Everything below only moves on a baud tick; other cycles hold.
   always_comb begin
      state_nx    = state;
      tick_cnt_nx = tick_cnt;
      bit_cnt_nx  = bit_cnt;
      shreg_nx    = shreg;
      valid_nx    = 1'b0;
      err_nx      = 1'b0;
      if (baud_tick) begin
         unique case (state)
            IDLE: begin
               if (!rx_s) begin
                  state_nx    = START;
                  tick_cnt_nx = '0;
               end
            end
            START: begin
               if (tick_cnt == TICK_MID) begin
                  if (rx_s) begin
                     state_nx = IDLE;
                  end else begin
                     state_nx    = DATA;
                     tick_cnt_nx = '0;
                     bit_cnt_nx  = '0;
                  end
               end else begin
                  tick_cnt_nx = tick_cnt + TICK_ONE;
               end
            end
            DATA: begin
               if (tick_cnt == TICK_LAST) begin
                  shreg_nx    = {rx_s, shreg[DATA_BITS-1:1]};
                  tick_cnt_nx = '0;
                  bit_cnt_nx  = bit_cnt + BIT_ONE;
                  if (bit_cnt == BIT_LAST) begin
                     state_nx = STOP;
                  end
               end else begin
                  tick_cnt_nx = tick_cnt + TICK_ONE;
               end
            end
            STOP: begin
               // Leaving at mid stop bit allows zero-gap back-to-back frames.
               if (tick_cnt == TICK_LAST) begin
                  tick_cnt_nx = '0;
                  if (rx_s) begin
                     valid_nx = 1'b1;
                     state_nx = IDLE;
                  end else begin
                     err_nx   = 1'b1;
                     state_nx = BREAK;
                  end
               end else begin
                  tick_cnt_nx = tick_cnt + TICK_ONE;
               end
            end
            BREAK: begin
               if (rx_s) begin
                  state_nx = IDLE;
               end
            end
            default: begin
               state_nx = IDLE;
            end
         endcase
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_oversample.sv
// tb/tb_uart_rx_oversample.sv - randomized bench checking the receiver against a tick-level frame decoder
// The line level is planned per baud tick; the model decodes that plan into expected strobes and busy.
module tb_uart_rx_oversample;

   localparam int DB        = 8;
   localparam int OS        = 16;
   localparam int HALF      = OS / 2;
   localparam int DIV       = 6;
   localparam int STALL_CLK = 1000;

   logic          clk       = 1'b0;
   logic          rst       = 1'b1;
   logic          baud_tick = 1'b0;
   logic          rx        = 1'b1;
   logic [DB-1:0] rx_data;
   logic          rx_valid;
   logic          frame_err;
   logic          busy;

   uart_rx_oversample #(
      .DATA_BITS (DB),
      .OVERSAMPLE(OS)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .baud_tick(baud_tick),
      .rx       (rx),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .frame_err(frame_err),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   bit            lvl[$];
   int            ev_kind[];
   logic [DB-1:0] ev_data[];
   bit            busy_after[];
   int            cp_tick[$];
   logic [DB-1:0] cp_val[$];
   int            rst_tick   = -1;
   int            stall_tick = -1;
   int            t1, t2, t3, t4;
   int            n_vec = 0;
   int            n_bad = 0;
   bit            run = 1'b0;
   int            tick_no = 0;
   int            edge_idx = 0;
   bit            edge_tick = 1'b0;
   bit            edge_rst = 1'b0;
   logic [DB-1:0] exp_data = '0;
   logic          exp_busy = 1'b0;
   logic          exp_v;
   logic          exp_e;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic put(input bit v, input int n);
      repeat (n) lvl.push_back(v);
   endtask

   task automatic frame(input logic [DB-1:0] d, input bit stop);
      put(1'b0, OS);
      for (int k = 0; k < DB; k++) put(d[k], OS);
      put(stop, OS);
   endtask

   task automatic checkpoint(input logic [DB-1:0] v);
      cp_tick.push_back(lvl.size() - 1);
      cp_val.push_back(v);
   endtask

   function automatic bit lv(input int i);
      if (i >= lvl.size()) return 1'b1;
      return lvl[i];
   endfunction

   // Decode the sampled line between ticks s and e into frame events and busy spans.
   task automatic scan(input int s, input int e);
      int            pos, t, fin;
      logic [DB-1:0] d;
      pos = s;
      while (pos < e) begin
         if (lv(pos)) begin
            pos++;
            continue;
         end
         t = pos;
         if (lv(t + HALF)) begin
            fin = t + HALF;
         end else begin
            for (int k = 0; k < DB; k++) d[k] = lv(t + HALF + OS * (k + 1));
            fin = t + HALF + OS * (DB + 1);
            if (fin < e) begin
               if (lv(fin)) begin
                  ev_kind[fin] = 1;
                  ev_data[fin] = d;
               end else begin
                  ev_kind[fin] = 2;
                  fin++;
                  while (fin < lvl.size() && !lv(fin)) fin++;
               end
            end
         end
         for (int i = t; i < fin && i < e; i++) busy_after[i] = 1'b1;
         pos = fin + 1;
      end
   endtask

   task automatic build();
      put(1'b1, 2 * OS);
      t1 = lvl.size();
      frame(8'h55, 1'b1);
      put(1'b1, 2 * OS);
      checkpoint(8'h55);
      t2 = lvl.size();
      put(1'b0, 3);
      put(1'b1, 2 * OS);
      checkpoint(8'h55);
      t3 = lvl.size();
      frame(8'hA3, 1'b0);
      put(1'b0, 20 * OS);
      put(1'b1, 2 * OS);
      checkpoint(8'h55);
      frame(8'h0F, 1'b1);
      put(1'b1, 2 * OS);
      checkpoint(8'h0F);
      t4 = lvl.size();
      frame(8'h00, 1'b1);
      frame(8'hFF, 1'b1);
      frame(8'h81, 1'b1);
      put(1'b1, 2 * OS);
      checkpoint(8'h81);
      rst_tick = lvl.size() + OS * 5 + HALF;
      frame(8'h3C, 1'b1);
      put(1'b1, 12 * OS);
      frame(8'h3C, 1'b1);
      put(1'b1, 2 * OS);
      checkpoint(8'h3C);
      stall_tick = lvl.size() + OS * 4 + 3;
      frame(8'h96, 1'b1);
      put(1'b1, 2 * OS);
      checkpoint(8'h96);
      for (int i = 0; i < 25; i++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r == 0) begin
            put(1'b0, $urandom_range(1, HALF - 1));
            put(1'b1, $urandom_range(HALF + 1, 2 * OS));
         end else begin
            frame(DB'($urandom), r != 1);
            if (r == 1) put(1'b0, $urandom_range(0, 60));
            put(1'b1, $urandom_range(0, 24));
         end
      end
      put(1'b1, 2 * OS);
   endtask

   // Hand-derived positions: a frame starting at tick t completes at t + 8 + 16*9 = t + 152.
   task automatic pin_model();
      int cnt;
      check("model t1 kind", ev_kind[t1 + 152], 1);
      check("model t1 data", ev_data[t1 + 152], 8'h55);
      check("model t1 busy pre", busy_after[t1 - 1], 0);
      check("model t1 busy last", busy_after[t1 + 151], 1);
      check("model t1 busy end", busy_after[t1 + 152], 0);
      check("model glitch busy", busy_after[t2 + 7], 1);
      check("model glitch idle", busy_after[t2 + 8], 0);
      cnt = 0;
      for (int i = t2; i < t3; i++) if (ev_kind[i] != 0) cnt++;
      check("model glitch events", cnt, 0);
      check("model t3 err", ev_kind[t3 + 152], 2);
      check("model t4 a", {ev_kind[t4 + 152], 8'(ev_data[t4 + 152])}, {32'd1, 8'h00});
      check("model t4 b", {ev_kind[t4 + 312], 8'(ev_data[t4 + 312])}, {32'd1, 8'hFF});
      check("model t4 c", {ev_kind[t4 + 472], 8'(ev_data[t4 + 472])}, {32'd1, 8'h81});
   endtask

   always @(posedge clk) begin
      edge_tick <= baud_tick;
      edge_rst  <= rst;
      edge_idx  <= tick_no;
      if (baud_tick) tick_no <= tick_no + 1;
   end

   always @(negedge clk) begin
      if (run) begin
         exp_v = 1'b0;
         exp_e = 1'b0;
         if (edge_rst) begin
            exp_data = '0;
            exp_busy = 1'b0;
         end else if (edge_tick && edge_idx < lvl.size()) begin
            exp_busy = busy_after[edge_idx];
            if (ev_kind[edge_idx] == 1) begin
               exp_v    = 1'b1;
               exp_data = ev_data[edge_idx];
            end else if (ev_kind[edge_idx] == 2) begin
               exp_e = 1'b1;
            end
         end
         check("rx_valid", 32'(rx_valid), 32'(exp_v));
         check("frame_err", 32'(frame_err), 32'(exp_e));
         check("rx_data", 32'(rx_data), 32'(exp_data));
         check("busy", 32'(busy), 32'(exp_busy));
      end
   end

   initial begin
      int cp_idx;
      cp_idx = 0;
      build();
      ev_kind    = new[lvl.size()];
      ev_data    = new[lvl.size()];
      busy_after = new[lvl.size()];
      foreach (ev_data[i]) ev_data[i] = '0;
      scan(0, rst_tick);
      scan(rst_tick, lvl.size());
      pin_model();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run = 1'b1;
      check("reset rx_data", 32'(rx_data), 0);
      check("reset rx_valid", 32'(rx_valid), 0);
      check("reset frame_err", 32'(frame_err), 0);
      check("reset busy", 32'(busy), 0);
      for (int n = 0; n < lvl.size(); n++) begin
         rx        = lvl[n];
         baud_tick = 1'b0;
         rst       = 1'b0;
         if (n == stall_tick) begin
            check("stall busy start", 32'(busy), 1);
            repeat (STALL_CLK) @(negedge clk);
            check("stall busy end", 32'(busy), 1);
         end
         for (int j = 0; j < DIV; j++) begin
            rst       = (n == rst_tick && j == 0);
            baud_tick = (j == DIV - 1);
            @(negedge clk);
            if (n == rst_tick && j == 0) begin
               check("post-rst rx_data", 32'(rx_data), 0);
               check("post-rst rx_valid", 32'(rx_valid), 0);
               check("post-rst frame_err", 32'(frame_err), 0);
               check("post-rst busy", 32'(busy), 0);
            end
         end
         if (cp_idx < cp_tick.size() && cp_tick[cp_idx] == n) begin
            check("checkpoint rx_data", 32'(rx_data), 32'(cp_val[cp_idx]));
            cp_idx++;
         end
      end
      baud_tick = 1'b0;
      repeat (4) @(negedge clk);
      check("checkpoints reached", cp_idx, cp_tick.size());
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
